imm_extender_pipe: RTL and testbench

IMM_EXTENDER_PIPE -- requirements
Module: imm_extender_pipe

---
 rtl/imm_extender_pipe_pkg.sv | 18 +
 rtl/imm_extender_pipe_if.sv | 25 ++
 rtl/imm_extender_pipe_core.sv | 55 +++++
 rtl/imm_extender_pipe.sv | 79 +++++++
 tb/tb_imm_extender_pipe.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/imm_extender_pipe_pkg.sv
// Shared format encodings and default field widths for the immediate extender.
package imm_pkg;

  typedef enum logic [1:0] {
    FMT_J   = 2'd0,
    FMT_I20 = 2'd1,
    FMT_I14 = 2'd2,
    FMT_B8  = 2'd3
  } fmt_e;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_W0     = 26;
  localparam int unsigned DEF_W1     = 20;
  localparam int unsigned DEF_W2     = 14;
  localparam int unsigned DEF_W3     = 8;
  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/imm_extender_pipe_if.sv
// Request/response bundle between a producer, the extender and its consumer.
interface imm_extender_pipe_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] instr;
  logic [1:0]        im_sel;
  logic              zero_ext;
  logic              shl2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] sinal_estendido;
  logic              sel_err;

  modport slave (
    input  in_valid, instr, im_sel, zero_ext, shl2, out_ready,
    output in_ready, out_valid, sinal_estendido, sel_err
  );

  modport master (
    output in_valid, instr, im_sel, zero_ext, shl2, out_ready,
    input  in_ready, out_valid, sinal_estendido, sel_err
  );
endinterface

// File: rtl/imm_extender_pipe_core.sv
// Combinational field extraction, sign/zero extension and optional word shift.
module imm_ext_core
  import imm_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned W0       = DEF_W0,
  parameter int unsigned W1       = DEF_W1,
  parameter int unsigned W2       = DEF_W2,
  parameter int unsigned W3       = DEF_W3,
  parameter logic [3:0]  MASK_FMT = 4'b0000
) (
  input  logic [DATA_W-1:0] i_instr,
  input  logic [1:0]        i_im_sel,
  input  logic              i_zero_ext,
  input  logic              i_shl2,
  output logic [DATA_W-1:0] o_result_c,
  output logic              o_sel_err_c
);

  localparam int unsigned IDX_W = $clog2(DATA_W);

  logic [31:0]       w_width;
  logic [DATA_W-1:0] w_ext;

  // Keep the low w bits; fill the rest with zeros or copies of bit w-1.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] instr,
                                               input logic [31:0]       w,
                                               input logic              zero);
    logic [DATA_W-1:0] mask;
    logic              sign;
    mask = ~({DATA_W{1'b1}} << w);
    sign = instr[IDX_W'(w - 32'd1)];
    return (zero || !sign) ? (instr & mask) : (instr | ~mask);
  endfunction

  always_comb begin
    w_width     = W0;
    o_result_c  = '0;
    o_sel_err_c = 1'b0;
    case (fmt_e'(i_im_sel))
      FMT_J:   w_width = W0;
      FMT_I20: w_width = W1;
      FMT_I14: w_width = W2;
      FMT_B8:  w_width = W3;
      default: w_width = W0;
    endcase
    w_ext = extend(i_instr, w_width, i_zero_ext);
    if (MASK_FMT[i_im_sel]) begin
      o_sel_err_c = 1'b1;
    end else begin
      o_result_c = i_shl2 ? (w_ext << 2) : w_ext;
    end
  end

endmodule

// File: rtl/imm_extender_pipe.sv
// Immediate extender with a 2-entry result FIFO: 1-cycle latency, full throughput.
module imm_extender_pipe
  import imm_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned W0       = DEF_W0,
  parameter int unsigned W1       = DEF_W1,
  parameter int unsigned W2       = DEF_W2,
  parameter int unsigned W3       = DEF_W3,
  parameter logic [3:0]  MASK_FMT = 4'b0000
) (
  input  logic                clock,
  input  logic                reset,
  imm_extender_pipe_if.slave  bus
);

  logic [DATA_W-1:0] w_result;
  logic              w_err;
  logic              w_push;
  logic              w_pop;

  logic [1:0]        r_count;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [DATA_W-1:0] r_data [FIFO_DEPTH];
  logic              r_err  [FIFO_DEPTH];

  imm_ext_core #(
    .DATA_W   (DATA_W),
    .W0       (W0),
    .W1       (W1),
    .W2       (W2),
    .W3       (W3),
    .MASK_FMT (MASK_FMT)
  ) u_core (
    .i_instr     (bus.instr),
    .i_im_sel    (bus.im_sel),
    .i_zero_ext  (bus.zero_ext),
    .i_shl2      (bus.shl2),
    .o_result_c  (w_result),
    .o_sel_err_c (w_err)
  );

  // Ready depends only on the registered count, never on out_ready.
  assign bus.in_ready        = !reset && (r_count != 2'(FIFO_DEPTH));
  assign bus.out_valid       = (r_count != 2'd0);
  assign bus.sinal_estendido = r_data[r_rd_ptr];
  assign bus.sel_err         = r_err[r_rd_ptr];

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i] <= '0;
        r_err[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= w_result;
        r_err[r_wr_ptr]  <= w_err;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_imm_extender_pipe;

  localparam logic [3:0] MASK = 4'b1000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic [32:0] q [$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  imm_extender_pipe_if #(.DATA_W(32)) bus ();

  imm_extender_pipe #(
    .DATA_W   (32),
    .W0       (26),
    .W1       (20),
    .W2       (14),
    .W3       (8),
    .MASK_FMT (MASK)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: {sel_err, value} from the field-width arithmetic.
  function automatic logic [32:0] model(input logic [1:0] sel, input logic [31:0] ins,
                                        input logic z, input logic s);
    int unsigned w;
    logic [63:0] field, v;
    if (MASK[sel]) return {1'b1, 32'h0};
    case (sel)
      2'd0: w = 26;
      2'd1: w = 20;
      2'd2: w = 14;
      default: w = 8;
    endcase
    field = {32'h0, ins} & ((64'd1 << w) - 64'd1);
    v = field;
    if (!z && field[w-1]) v = field - (64'd1 << w);
    if (s) v = v * 64'd4;
    return {1'b0, v[31:0]};
  endfunction

  // Compare process: checks every cycle, then advances the model for the coming edge.
  always @(negedge clock) begin
    bit push, pop;
    if (reset) begin
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_result", 64'(bus.sinal_estendido), 64'd0);
      check("rst_sel_err", 64'(bus.sel_err), 64'd0);
      q.delete();
    end else begin
      check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      if (q.size() != 0) begin
        check("result", 64'(bus.sinal_estendido), 64'(q[0][31:0]));
        check("sel_err", 64'(bus.sel_err), 64'(q[0][32]));
      end
      push = bus.in_valid && (q.size() < 2);
      pop  = (q.size() != 0) && bus.out_ready;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(model(bus.im_sel, bus.instr, bus.zero_ext, bus.shl2));
    end
  end

  task automatic send(input logic [1:0] sel, input logic [31:0] ins, input logic z, input logic s);
    bit acc;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.im_sel   = sel;
    bus.instr    = ins;
    bus.zero_ext = z;
    bus.shl2     = s;
    do begin
      @(negedge clock);
      acc = bus.in_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!acc && n < 50);
    check("send_accept", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    logic [31:0] exp3 [3];
    int t0;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.im_sel    = '0;
    bus.zero_ext  = 1'b0;
    bus.shl2      = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);

    // Sign-extended 26-bit field, 1-cycle latency
    send(2'd0, 32'h0200_0000, 1'b0, 1'b0);
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("fmt0_sign", 64'(bus.sinal_estendido), 64'hFE00_0000);
    idle(1);
    send(2'd2, 32'h0000_2001, 1'b1, 1'b1);
    check("fmt2_zero_shl", 64'(bus.sinal_estendido), 64'h0000_8004);
    send(2'd2, 32'h0000_2001, 1'b0, 1'b1);
    check("fmt2_sign_shl", 64'(bus.sinal_estendido), 64'hFFFF_8004);
    idle(2);

    // Backpressure: two buffered, third stalls, then drains in order
    bus.out_ready = 1'b0;
    send(2'd1, 32'h0007_FFFF, 1'b0, 1'b0);
    send(2'd1, 32'h0008_0000, 1'b0, 1'b0);
    exp3[0] = 32'h0007_FFFF;
    exp3[1] = 32'hFFF8_0000;
    exp3[2] = 32'h0000_0001;
    bus.out_ready = 1'b1;
    fork
      send(2'd1, 32'h0000_0001, 1'b0, 1'b0);
      begin
        @(negedge clock);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("order_0", 64'(bus.sinal_estendido), 64'(exp3[0]));
        for (int k = 1; k < 3; k++) begin
          @(negedge clock);
          check("order_valid", 64'(bus.out_valid), 64'd1);
          check("order_k", 64'(bus.sinal_estendido), 64'(exp3[k]));
        end
      end
    join
    idle(2);

    // Streaming: 8 requests in 8 cycles with simultaneous push/pop
    t0 = cyc;
    for (int i = 0; i < 8; i++)
      send(2'($urandom_range(0, 2)), $urandom, 1'($urandom), 1'($urandom));
    check("stream_cycles", 64'(cyc - t0), 64'd8);
    idle(2);

    // Masked format yields zero with error; next valid format clears error
    send(2'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("mask_result", 64'(bus.sinal_estendido), 64'd0);
    check("mask_err", 64'(bus.sel_err), 64'd1);
    send(2'd1, 32'h0000_0005, 1'b0, 1'b0);
    check("unmask_err", 64'(bus.sel_err), 64'd0);
    check("unmask_result", 64'(bus.sinal_estendido), 64'h0000_0005);
    idle(2);

    // Reset with two entries buffered
    bus.out_ready = 1'b0;
    send(2'd0, 32'h0123_4567, 1'b0, 1'b0);
    send(2'd2, 32'h0000_3FFF, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    idle(1);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("post_rst_valid", 64'(bus.out_valid), 64'd0);
    idle(3);

    // Random traffic against the model
    repeat (400) begin
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      bus.im_sel    = 2'($urandom);
      bus.instr     = $urandom;
      bus.zero_ext  = 1'($urandom);
      bus.shl2      = 1'($urandom);
      idle(1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
